control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/ctrl_pkg.sv | 86 ++++++++
 rtl/seq_next_state.sv | 42 ++++
 rtl/control_sequencer.sv | 59 +++++
 tb/tb_control_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Micro-state and instruction codes shared by the sequencer and the control decoder.
// An instruction code is the code of its first micro-step, so dispatch is a direct cast.
package ctrl_pkg;

    typedef enum logic [7:0] {
        FETCH   = 8'h00, FETCH_2 = 8'h01, FETCH_3 = 8'h02,
        LODK    = 8'h10, LODK_2  = 8'h11,
        LADD    = 8'h20, LADD_2  = 8'h21, LADD_3  = 8'h22, LADD_4 = 8'h23,
        LADD_5  = 8'h24, LADD_6  = 8'h25, LADD_7  = 8'h26,
        LOAD    = 8'h30, LOAD_2  = 8'h31, LOAD_3  = 8'h32,
        STAC    = 8'h40,
        COPY    = 8'h50, COPY_2  = 8'h51,
        RSET    = 8'h60, RSET_2  = 8'h61,
        JUMP    = 8'h70, JUMP_2  = 8'h71,
        INCR    = 8'h80, INCR_2  = 8'h81,
        DECR    = 8'h90, DECR_2  = 8'h91,
        ADD     = 8'hA0, SUBT    = 8'hA8,
        DIV     = 8'hB0, DIV_2   = 8'hB1,
        MUL     = 8'hC0, MUL_2   = 8'hC1,
        TOGL    = 8'hD0, NOOP    = 8'hE0,
        END     = 8'hF0
    } ustate_t;

    typedef struct packed {
        ustate_t    nxt;
        logic       ir_load;
        logic [7:0] ir_val;
        logic       illegal;
        logic       retire;
    } step_res_t;

    function automatic logic is_legal_instr(input logic [7:0] c);
        case (c)
            LODK, LADD, LOAD, STAC, COPY, RSET, JUMP, INCR,
            DECR, ADD, SUBT, DIV, MUL, TOGL, NOOP, END: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_step(input ustate_t s);
        case (s)
            FETCH_2, LODK, LADD, LADD_3, LADD_5, LOAD_3, STAC,
            COPY, RSET, JUMP, INCR, DECR, DIV, MUL: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic is_alu_step(input ustate_t s);
        return (s == DIV_2) || (s == MUL_2);
    endfunction

    function automatic logic is_final_step(input ustate_t s);
        case (s)
            LODK_2, LADD_7, LOAD_3, STAC, COPY_2, RSET_2, JUMP_2, INCR_2,
            DECR_2, ADD, SUBT, DIV_2, MUL_2, TOGL, NOOP: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    // Successor inside a step chain; final steps and unknown codes fall back to FETCH.
    function automatic ustate_t chain_next(input ustate_t s);
        case (s)
            FETCH:   return FETCH_2;
            FETCH_2: return FETCH_3;
            LODK:    return LODK_2;
            LADD:    return LADD_2;
            LADD_2:  return LADD_3;
            LADD_3:  return LADD_4;
            LADD_4:  return LADD_5;
            LADD_5:  return LADD_6;
            LADD_6:  return LADD_7;
            LOAD:    return LOAD_2;
            LOAD_2:  return LOAD_3;
            COPY:    return COPY_2;
            RSET:    return RSET_2;
            JUMP:    return JUMP_2;
            INCR:    return INCR_2;
            DECR:    return DECR_2;
            DIV:     return DIV_2;
            MUL:     return MUL_2;
            END:     return END;
            default: return FETCH;
        endcase
    endfunction

endpackage

// File: rtl/seq_next_state.sv
// Combinational next-step and dispatch logic for the control sequencer.
module seq_next_state
    import ctrl_pkg::*;
(
    input  ustate_t    cur,
    input  logic [7:0] instr,
    input  logic       mem_ready,
    input  logic       alu_done,
    output step_res_t  res
);

    logic legal;
    logic stall;

    always_comb begin
        legal = is_legal_instr(instr);
        stall = (is_mem_step(cur) && !mem_ready) || (is_alu_step(cur) && !alu_done);

        res.nxt     = cur;
        res.ir_load = 1'b0;
        res.ir_val  = NOOP;
        res.illegal = 1'b0;
        res.retire  = 1'b0;

        if (cur == FETCH_3) begin
            res.ir_load = 1'b1;
            if (legal) begin
                res.nxt    = ustate_t'(instr);
                res.ir_val = instr;
                res.retire = (instr == END);
            end else begin
                // undefined codes run as a NOOP
                res.nxt     = NOOP;
                res.illegal = 1'b1;
            end
        end else if (!stall) begin
            res.nxt    = chain_next(cur);
            res.retire = is_final_step(cur);
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Micro-step sequencer: fetch, dispatch and step chains with memory/ALU waits.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       instr,
    input  logic             mem_ready,
    input  logic             alu_done,
    output logic [7:0]       operand,
    output logic [7:0]       ir,
    output logic             halted,
    output logic             illegal,
    output logic             retired,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ustate_t   state;
    step_res_t step;

    seq_next_state u_next (
        .cur       (state),
        .instr     (instr),
        .mem_ready (mem_ready),
        .alu_done  (alu_done),
        .res       (step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            ir          <= NOOP;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            retired     <= 1'b0;
            retired_cnt <= '0;
        end else if (!en) begin
            illegal <= 1'b0;
            retired <= 1'b0;
        end else begin
            state   <= step.nxt;
            halted  <= (step.nxt == END);
            illegal <= step.illegal;
            retired <= step.retire;
            if (step.ir_load)
                ir <= step.ir_val;
            if (step.retire)
                retired_cnt <= retired_cnt + CNT_ONE;
        end
    end

    assign operand = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus random traffic against a step-list model.
module tb_control_sequencer;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, mem_ready, alu_done;
    logic [7:0]  instr;
    logic [7:0]  operand, ir, operand4, ir4;
    logic        halted, illegal, retired, halted4, illegal4, retired4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .instr(instr), .mem_ready(mem_ready),
        .alu_done(alu_done), .operand(operand), .ir(ir), .halted(halted),
        .illegal(illegal), .retired(retired), .retired_cnt(cnt)
    );

    control_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .instr(instr), .mem_ready(mem_ready),
        .alu_done(alu_done), .operand(operand4), .ir(ir4), .halted(halted4),
        .illegal(illegal4), .retired(retired4), .retired_cnt(cnt4)
    );

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: each instruction is a list of steps consumed one per advancing cycle.
    logic [7:0] m_op = FETCH, m_ir = NOOP;
    logic       m_halt = 1'b0, m_ill = 1'b0, m_ret = 1'b0;
    int         m_cnt = 0;
    logic [7:0] plan[$];

    logic [7:0] legal_codes [16] = '{LODK, LADD, LOAD, STAC, COPY, RSET, JUMP, INCR,
                                     DECR, ADD, SUBT, DIV, MUL, TOGL, NOOP, END};
    logic [7:0] ladd_seq [10] = '{FETCH_2, FETCH_3, LADD, LADD_2, LADD_3, LADD_4,
                                  LADD_5, LADD_6, LADD_7, FETCH};

    function automatic bit is_mem(input logic [7:0] s);
        return s inside {FETCH_2, LODK, LADD, LADD_3, LADD_5, LOAD_3, STAC,
                         COPY, RSET, JUMP, INCR, DECR, DIV, MUL};
    endfunction

    task automatic load_plan(input logic [7:0] c);
        case (c)
            LODK:    plan = {LODK, LODK_2};
            LADD:    plan = {LADD, LADD_2, LADD_3, LADD_4, LADD_5, LADD_6, LADD_7};
            LOAD:    plan = {LOAD, LOAD_2, LOAD_3};
            COPY:    plan = {COPY, COPY_2};
            RSET:    plan = {RSET, RSET_2};
            JUMP:    plan = {JUMP, JUMP_2};
            INCR:    plan = {INCR, INCR_2};
            DECR:    plan = {DECR, DECR_2};
            DIV:     plan = {DIV, DIV_2};
            MUL:     plan = {MUL, MUL_2};
            STAC:    plan = {STAC};
            ADD:     plan = {ADD};
            SUBT:    plan = {SUBT};
            TOGL:    plan = {TOGL};
            NOOP:    plan = {NOOP};
            END:     plan = {END};
            default: plan = {};
        endcase
    endtask

    task automatic model_next();
        if (rst) begin
            m_op = FETCH; m_ir = NOOP; m_ill = 1'b0; m_ret = 1'b0; m_cnt = 0; plan = {};
        end else if (!en) begin
            m_ill = 1'b0; m_ret = 1'b0;
        end else begin
            m_ill = 1'b0; m_ret = 1'b0;
            if (m_op == END) begin
            end else if ((is_mem(m_op) && !mem_ready) ||
                         ((m_op == DIV_2 || m_op == MUL_2) && !alu_done)) begin
            end else if (m_op == FETCH) begin
                m_op = FETCH_2;
            end else if (m_op == FETCH_2) begin
                m_op = FETCH_3;
            end else if (m_op == FETCH_3) begin
                load_plan(instr);
                if (plan.size() == 0) begin
                    m_ill = 1'b1; m_ir = NOOP; load_plan(NOOP);
                end else begin
                    m_ir = instr;
                end
                m_op = plan.pop_front();
                if (m_op == END) begin m_ret = 1'b1; m_cnt++; end
            end else if (plan.size() == 0) begin
                m_op = FETCH; m_ret = 1'b1; m_cnt++;
            end else begin
                m_op = plan.pop_front();
            end
        end
        m_halt = (m_op == END);
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
        check("operand", operand, m_op);
        check("ir", ir, m_ir);
        check("halted", halted, m_halt);
        check("illegal", illegal, m_ill);
        check("retired", retired, m_ret);
        check("retired_cnt", cnt, m_cnt[15:0]);
        check("retired_cnt4", cnt4, m_cnt[3:0]);
        check("operand4", operand4, m_op);
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0; en = 1'b1;
    endtask

    initial begin
        int k, held, rp;
        bit hit;
        rst = 1'b1; en = 1'b1; mem_ready = 1'b1; alu_done = 1'b0; instr = NOOP;

        // reset with en low still clears everything
        en = 1'b0; do_reset();
        check("rst_op", operand, FETCH);
        check("rst_ir", ir, NOOP);
        check("rst_cnt", cnt, 0);

        // LADD chain, no waits
        instr = LADD; rp = 0;
        for (int i = 0; i < 10; i++) begin
            tick(); check("ladd_seq", operand, ladd_seq[i]); rp += int'(retired);
        end
        check("ladd_ret", rp, 1);
        check("ladd_cnt", cnt, 1);

        // LOAD with three wait cycles in LOAD_3
        do_reset(); instr = LOAD; k = 0; held = 0;
        for (int i = 0; i < 30; i++) begin
            mem_ready = !(m_op == LOAD_3 && k < 3);
            if (m_op == LOAD_3) k++;
            tick();
            if (operand == LOAD_3) held++;
            if (k > 0 && m_op == FETCH) break;
        end
        mem_ready = 1'b1;
        check("load_hold", held, 4);
        check("load_fetch", operand, FETCH);

        // MUL with alu_done five cycles after MUL_2 entry
        do_reset(); instr = MUL; k = 0; held = 0; rp = 0;
        for (int i = 0; i < 30; i++) begin
            alu_done = (m_op == MUL_2 && k >= 5);
            if (m_op == MUL_2) k++;
            tick();
            if (operand == MUL_2) held++;
            rp += int'(retired);
            if (k > 0 && m_op == FETCH) break;
        end
        alu_done = 1'b0;
        check("mul_hold", held, 6);
        check("mul_ret", rp, 1);

        // undefined instruction
        do_reset(); instr = 8'hFF;
        repeat (3) tick();
        check("ill_pulse", illegal, 1);
        check("ill_ir", ir, NOOP);
        check("ill_op", operand, NOOP);
        tick();
        check("ill_clear", illegal, 0);
        check("ill_fetch", operand, FETCH);
        check("ill_cnt", cnt, 1);

        // END is sticky until reset
        do_reset(); instr = END;
        repeat (3) tick();
        check("end_cnt", cnt, 1);
        instr = NOOP; held = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(1)); alu_done = 1'($urandom_range(1));
            tick();
            if (operand == END && halted) held++;
        end
        check("end_hold", held, 20);
        mem_ready = 1'b1; alu_done = 1'b0; do_reset();
        check("end_rst_op", operand, FETCH);
        check("end_rst_halt", halted, 0);

        // reset mid-instruction in LADD_4, with en low
        instr = NOOP; repeat (4) tick();
        check("pre_cnt", cnt, 1);
        instr = LADD; hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin tick(); hit = (m_op == LADD_4); end
        check("reach_ladd4", hit, 1);
        en = 1'b0; do_reset();
        check("ladd4_rst_op", operand, FETCH);
        check("ladd4_rst_cnt", cnt, 0);

        // 16 NOOPs wrap the 4-bit counter
        instr = NOOP; repeat (64) tick();
        check("wrap_cnt16", cnt, 16);
        check("wrap_cnt4", cnt4, 0);

        // random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(99) == 0);
            en        = ($urandom_range(7) != 0);
            mem_ready = ($urandom_range(2) != 0);
            alu_done  = ($urandom_range(3) == 0);
            instr     = ($urandom_range(9) < 8) ? legal_codes[$urandom_range(15)]
                                                : 8'($urandom_range(255));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
